// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the shared-LFSR random source.
package lfsr_pkg;

    localparam int unsigned      LFSR_W       = 16;
    localparam logic [15:0]      DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0]      DEFAULT_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } state_e;

    // One Galois step: shift right, fold the taps back in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q,
                                                    input logic [LFSR_W-1:0] taps);
        return (q >> 1) ^ (q[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Galois LFSR register: holds Q, steps or loads on request.
module lfsr16_core
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    output logic [LFSR_W-1:0] q_o
);

    logic [LFSR_W-1:0] q_q, q_d;

    // Next Q: a load takes precedence over a step.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (step_i) begin
            q_d = lfsr_next(q_q, TAPS);
        end
    end

    // State register, seeded on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin controller sharing one LFSR among NREQ requesters.
// Optional macro LFSR_PERIOD_CHECK_EN adds a period-wrap detector.
module lfsr_share_ctrl
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = DEFAULT_SEED,
    parameter int unsigned       NREQ  = 4,
    parameter int unsigned       STEPS = 1,
    parameter logic [LFSR_W-1:0] TAPS  = DEFAULT_TAPS
) (
    input  logic              CLK,
    input  logic              n_RESET,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [LFSR_W-1:0] rnd,
    input  logic              seed_we,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              seed_err,
    output logic              period_wrap
);

    localparam int unsigned IDXW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0]  CNT_INIT = 4'(STEPS - 1);

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              seed_err_q, seed_err_d;

    logic              core_step;
    logic              core_load;
    logic [LFSR_W-1:0] core_load_val;
    logic [LFSR_W-1:0] q;

    logic              found;
    logic [IDXW-1:0]   pick;

    lfsr16_core #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_core (
        .clk_i      (CLK),
        .rst_ni     (n_RESET),
        .step_i     (core_step),
        .load_i     (core_load),
        .load_val_i (core_load_val),
        .q_o        (q)
    );

    // Round-robin pick: first set request searching upward from rr_q with wrap.
    always_comb begin : arb
        int unsigned j;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = 32'(rr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!found && req[IDXW'(j)]) begin
                found = 1'b1;
                pick  = IDXW'(j);
            end
        end
    end

    // FSM next state, seed checking and LFSR control.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        seed_err_d    = 1'b0;
        core_step     = 1'b0;
        core_load     = 1'b0;
        core_load_val = SEED;
        case (state_q)
            IDLE: begin
                if (seed_we) begin
                    core_load = 1'b1;
                    if (seed_in == '0) begin
                        seed_err_d = 1'b1;
                    end else begin
                        core_load_val = seed_in;
                    end
                end else if (q == '0) begin
                    core_load = 1'b1;
                end else if (en && found) begin
                    idx_d   = pick;
                    cnt_d   = CNT_INIT;
                    state_d = STEP;
                end
            end
            STEP: begin
                core_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GRANT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            GRANT: begin
                if (idx_q == IDXW'(NREQ - 1)) begin
                    rr_d = '0;
                end else begin
                    rr_d = idx_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            seed_err_q <= seed_err_d;
        end
    end

    // Grant and word are driven only during GRANT.
    always_comb begin
        gnt = '0;
        rnd = '0;
        if (state_q == GRANT) begin
            gnt[idx_q] = 1'b1;
            rnd        = q;
        end
    end

    assign seed_err = seed_err_q;

`ifdef LFSR_PERIOD_CHECK_EN
    logic [LFSR_W-1:0] seed_copy_q;
    logic [15:0]       per_cnt_q;
    logic              wrap_q;
    logic [LFSR_W-1:0] q_next_w;

    assign q_next_w = lfsr_next(q, TAPS);

    // Track steps since the last load; flag the step that lands back on the seed.
    always_ff @(posedge CLK or negedge n_RESET) begin
        if (!n_RESET) begin
            seed_copy_q <= SEED;
            per_cnt_q   <= '0;
            wrap_q      <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (core_load) begin
                seed_copy_q <= core_load_val;
                per_cnt_q   <= '0;
            end else if (core_step) begin
                if (q_next_w == seed_copy_q) begin
                    wrap_q    <= 1'b1;
                    per_cnt_q <= '0;
                end else begin
                    per_cnt_q <= per_cnt_q + 16'd1;
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A maximal-length sequence must wrap after exactly 65535 steps.
    always_ff @(posedge CLK) begin
        if (n_RESET && core_step && !core_load && (q_next_w == seed_copy_q)) begin
            assert (per_cnt_q == 16'd65534)
                else $error("lfsr period wrap at count %0d", per_cnt_q);
        end
    end
`endif

    assign period_wrap = wrap_q;
`else
    assign period_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Scoreboard bench for lfsr_share_ctrl (STEPS=1 and STEPS=4 instances).
module tb_lfsr_share_ctrl;

    typedef struct {
        logic [3:0]  gnt;
        logic [15:0] rnd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pw_seen = 0;

    logic        CLK = 1'b0;
    logic        n_RESET, en, seed_we, seed_err, period_wrap;
    logic [3:0]  req, gnt;
    logic [15:0] rnd, seed_in;

    logic        n_RESET4, en4, seed_we4, seed_err4, period_wrap4;
    logic [3:0]  req4, gnt4;
    logic [15:0] rnd4, seed_in4;

    always #5 CLK = ~CLK;

    lfsr_share_ctrl #(
        .SEED(16'hACE1), .NREQ(4), .STEPS(1), .TAPS(16'hB400)
    ) dut (
        .CLK(CLK), .n_RESET(n_RESET), .en(en), .req(req), .gnt(gnt), .rnd(rnd),
        .seed_we(seed_we), .seed_in(seed_in), .seed_err(seed_err), .period_wrap(period_wrap)
    );

    lfsr_share_ctrl #(
        .SEED(16'hACE1), .NREQ(4), .STEPS(4), .TAPS(16'hB400)
    ) dut4 (
        .CLK(CLK), .n_RESET(n_RESET4), .en(en4), .req(req4), .gnt(gnt4), .rnd(rnd4),
        .seed_we(seed_we4), .seed_in(seed_in4), .seed_err(seed_err4), .period_wrap(period_wrap4)
    );

`ifdef LFSR_PERIOD_CHECK_EN
    logic        n_RESET16, seed_we16, seed_err16, period_wrap16;
    logic [3:0]  req16, gnt16;
    logic [15:0] rnd16, seed_in16;
    logic        en16;

    lfsr_share_ctrl #(
        .SEED(16'hACE1), .NREQ(4), .STEPS(16), .TAPS(16'hB400)
    ) dut16 (
        .CLK(CLK), .n_RESET(n_RESET16), .en(en16), .req(req16), .gnt(gnt16), .rnd(rnd16),
        .seed_we(seed_we16), .seed_in(seed_in16), .seed_err(seed_err16), .period_wrap(period_wrap16)
    );
`endif

    // The short-run instances never get near a full period.
    always @(negedge CLK) begin
        if (period_wrap === 1'b1 || period_wrap4 === 1'b1) pw_seen++;
    end

    // Wait for the next grant on the selected instance and check it against the scoreboard.
    task automatic wait_grant(input bit sel, input string name);
        exp_t        e;
        int          n;
        logic [3:0]  g;
        logic [15:0] r;
        n = 0;
        g = '0;
        r = '0;
        do begin
            @(negedge CLK);
            n++;
            g = sel ? gnt4 : gnt;
            r = sel ? rnd4 : rnd;
        end while (g == 4'b0 && n < 40);
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: grant %b with empty scoreboard", name, g);
            return;
        end
        e = sb.pop_front();
        total++;
        if (g !== e.gnt) begin
            bad++; $display("FAIL %s gnt: got=%b exp=%b", name, g, e.gnt);
        end
        total++;
        if (r !== e.rnd) begin
            bad++; $display("FAIL %s rnd: got=%h exp=%h", name, r, e.rnd);
        end
        total++;
        if (n !== e.lat) begin
            bad++; $display("FAIL %s latency: got=%0d exp=%0d", name, n, e.lat);
        end
    endtask

    task automatic test_reset();
        n_RESET = 1'b0; n_RESET4 = 1'b0;
        repeat (2) @(negedge CLK);
        total++;
        if (gnt !== 4'b0 || gnt4 !== 4'b0) begin
            bad++; $display("FAIL reset gnt: got=%b/%b exp=0000", gnt, gnt4);
        end
        total++;
        if (rnd !== 16'h0 || rnd4 !== 16'h0) begin
            bad++; $display("FAIL reset rnd: got=%h/%h exp=0000", rnd, rnd4);
        end
        total++;
        if (seed_err !== 1'b0 || period_wrap !== 1'b0) begin
            bad++; $display("FAIL reset flags: got=%b%b exp=00", seed_err, period_wrap);
        end
        n_RESET = 1'b1; n_RESET4 = 1'b1;
        repeat (3) @(negedge CLK);
        total++;
        if (gnt !== 4'b0) begin
            bad++; $display("FAIL idle gnt: got=%b exp=0000", gnt);
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        sb.push_back('{4'b0001, 16'hE270, 2});
        wait_grant(0, "single");
        req = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_round_robin();
        n_RESET = 1'b0;
        @(negedge CLK);
        n_RESET = 1'b1;
        @(negedge CLK);
        sb.push_back('{4'b0001, 16'hE270, 2});
        sb.push_back('{4'b0010, 16'h7138, 3});
        sb.push_back('{4'b0100, 16'h389C, 3});
        sb.push_back('{4'b1000, 16'h1C4E, 3});
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_grant(0, "round_robin");
            req = req & ~gnt;
        end
        req = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_zero_seed();
        seed_we = 1'b1; seed_in = 16'h0000;
        @(negedge CLK);
        seed_we = 1'b0;
        total++;
        if (seed_err !== 1'b1) begin
            bad++; $display("FAIL zero_seed err pulse: got=%b exp=1", seed_err);
        end
        @(negedge CLK);
        total++;
        if (seed_err !== 1'b0) begin
            bad++; $display("FAIL zero_seed err width: got=%b exp=0", seed_err);
        end
        req = 4'b0001;
        sb.push_back('{4'b0001, 16'hE270, 2});
        wait_grant(0, "zero_seed");
        req = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_seed_and_req();
        seed_we = 1'b1; seed_in = 16'h0001; req = 4'b0001;
        sb.push_back('{4'b0001, 16'hB400, 3});
        fork
            wait_grant(0, "seed_and_req");
            begin @(negedge CLK); seed_we = 1'b0; end
        join
        req = 4'b0000;
        total++;
        if (seed_err !== 1'b0) begin
            bad++; $display("FAIL seed_and_req err: got=%b exp=0", seed_err);
        end
        @(negedge CLK);
    endtask

    task automatic test_seed_ignored();
        req = 4'b0001;
        sb.push_back('{4'b0001, 16'h5A00, 2});
        fork
            wait_grant(0, "seed_ignored");
            begin
                @(negedge CLK); seed_we = 1'b1; seed_in = 16'h0000;
                @(negedge CLK); seed_we = 1'b0;
            end
        join
        req = 4'b0000;
        total++;
        if (seed_err !== 1'b0) begin
            bad++; $display("FAIL seed_ignored err: got=%b exp=0", seed_err);
        end
        @(negedge CLK);
    endtask

    task automatic test_enable();
        int stray;
        stray = 0;
        en = 1'b0; req = 4'b0010;
        repeat (6) begin
            @(negedge CLK);
            if (gnt !== 4'b0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL enable blocked: got=%0d grants exp=0", stray);
        end
        en = 1'b1;
        sb.push_back('{4'b0010, 16'h2D00, 2});
        fork
            wait_grant(0, "enable");
            begin @(negedge CLK); en = 1'b0; end
        join
        req = 4'b0000;
        en = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset_mid_step();
        int stray;
        stray = 0;
        req4 = 4'b0001;
        sb.push_back('{4'b0001, 16'h1C4E, 5});
        wait_grant(1, "steps4");
        req4 = 4'b0000;
        @(negedge CLK);
        req4 = 4'b0010;
        repeat (2) @(negedge CLK);
        n_RESET4 = 1'b0; req4 = 4'b0000;
        repeat (4) begin
            @(negedge CLK);
            if (gnt4 !== 4'b0) stray++;
        end
        n_RESET4 = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            if (gnt4 !== 4'b0) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++; $display("FAIL reset_mid_step aborted grant: got=%0d exp=0", stray);
        end
        req4 = 4'b1111;
        sb.push_back('{4'b0001, 16'h1C4E, 5});
        sb.push_back('{4'b0010, 16'hC2C4, 6});
        for (int k = 0; k < 2; k++) begin
            wait_grant(1, "after_reset");
            req4 = req4 & ~gnt4;
        end
        req4 = 4'b0000;
        @(negedge CLK);
    endtask

    task automatic test_period();
`ifdef LFSR_PERIOD_CHECK_EN
        int grants, n, zero_rnd;
        bit wrapped;
        grants = 0; n = 0; zero_rnd = 0; wrapped = 0;
        seed_we16 = 1'b1; seed_in16 = 16'h0001;
        @(negedge CLK);
        seed_we16 = 1'b0; req16 = 4'b0001;
        while (!wrapped && n < 80000) begin
            @(negedge CLK);
            n++;
            if (gnt16 !== 4'b0) begin
                grants++;
                if (rnd16 === 16'h0) zero_rnd++;
            end
            if (period_wrap16 === 1'b1) wrapped = 1;
        end
        total++;
        if (!wrapped || grants !== 4095) begin
            bad++; $display("FAIL period wrap: wrapped=%0d grants=%0d exp=1/4095", wrapped, grants);
        end
        @(negedge CLK);
        total++;
        if (period_wrap16 !== 1'b0 || zero_rnd !== 0 || seed_err16 !== 1'b0) begin
            bad++; $display("FAIL period pulse width/rnd: pw=%b zero_rnd=%0d exp=0/0", period_wrap16, zero_rnd);
        end
        req16 = 4'b0000;
`endif
        total++;
        if (pw_seen !== 0) begin
            bad++; $display("FAIL period_wrap short run: got=%0d pulses exp=0", pw_seen);
        end
    endtask

    initial begin
        n_RESET = 1'b0; en = 1'b1; req = '0; seed_we = 1'b0; seed_in = '0;
        n_RESET4 = 1'b0; en4 = 1'b1; req4 = '0; seed_we4 = 1'b0; seed_in4 = '0;
`ifdef LFSR_PERIOD_CHECK_EN
        n_RESET16 = 1'b0; en16 = 1'b1; req16 = '0; seed_we16 = 1'b0; seed_in16 = '0;
        #1 n_RESET16 = 1'b1;
`endif
        @(negedge CLK);
        test_reset();
        test_single();
        test_round_robin();
        test_zero_seed();
        test_seed_and_req();
        test_seed_ignored();
        test_enable();
        test_reset_mid_step();
        test_period();
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL scoreboard leftover: got=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
